// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared vectors, step and next-PC source encoding for the fetch sequencer
package pc_pkg;

    localparam int          DEF_STEP         = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_REDIR,
        SRC_RET,
        SRC_HOLD,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_top_idx;

    // r_ptr is the next write slot, so the top of stack sits one below it
    assign w_top_idx = r_ptr - 1'b1;
    assign dout      = r_mem[w_top_idx];
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_count != CW'(DEPTH))
                r_count <= r_count + 1'b1;
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            r_mem[r_ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with trap/redirect/return priority mux and RAS
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter int              STEP         = DEF_STEP,
    parameter int              RAS_DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(DEF_TRAP_VECTOR),
    localparam int             CW           = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clockin,
    input  logic              reset,
    input  logic              stall,
    input  logic              trap,
    input  logic              redirect_valid,
    input  logic              redirect_call,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              ret_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [CW-1:0]     ras_count,
    output logic              ras_underflow
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << $clog2(STEP);
    localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic              r_underflow;

    pc_src_e           w_src;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_ras_dout;
    logic [CW-1:0]     w_ras_count;
    logic              w_ras_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;

    assign w_ras_empty = (w_ras_count == '0);

    // Until pc_valid is up every request is ignored and pc holds at the reset vector
    always_comb begin
        w_src = SRC_SEQ;
        if (!r_pc_valid)
            w_src = SRC_HOLD;
        else if (trap)
            w_src = SRC_TRAP;
        else if (redirect_valid)
            w_src = SRC_REDIR;
        else if (ret_valid && !stall)
            w_src = SRC_RET;
        else if (stall)
            w_src = SRC_HOLD;
    end

    assign w_clear = (w_src == SRC_TRAP);
    assign w_push  = (w_src == SRC_REDIR) && redirect_call && !stall;
    assign w_pop   = (w_src == SRC_RET) && !w_ras_empty;

    always_comb begin
        w_next_pc = r_pc;
        case (w_src)
            SRC_TRAP:  w_next_pc = TRAP_VECTOR;
            SRC_REDIR: w_next_pc = redirect_target & ALIGN_MASK;
            SRC_RET:   w_next_pc = w_ras_empty ? TRAP_VECTOR : (w_ras_dout & ALIGN_MASK);
            SRC_HOLD:  w_next_pc = r_pc;
            SRC_SEQ:   w_next_pc = r_pc + STEP_W;
            default:   w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_pc_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_pc_valid  <= 1'b1;
            r_underflow <= (w_src == SRC_RET) && w_ras_empty;
        end
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clockin),
        .rst   (reset),
        .clear (w_clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_pc + STEP_W),
        .dout  (w_ras_dout),
        .count (w_ras_count)
    );

    assign pc            = r_pc;
    assign pc_valid      = r_pc_valid;
    assign ras_count     = w_ras_count;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench: driver queues expected state, monitor compares after each edge
module tb_pc_sequencer;

    logic        clockin = 1'b0;
    logic        reset   = 1'b1;
    logic        stall   = 1'b0;
    logic        trap    = 1'b0;
    logic        redirect_valid  = 1'b0;
    logic        redirect_call   = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        ret_valid = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [3:0]  ras_count;
    logic        ras_underflow;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic [3:0]  cnt;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer dut (
        .clockin         (clockin),
        .reset           (reset),
        .stall           (stall),
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_call   (redirect_call),
        .redirect_target (redirect_target),
        .ret_valid       (ret_valid),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .ras_count       (ras_count),
        .ras_underflow   (ras_underflow)
    );

    always #5 clockin = ~clockin;

    // Monitor: one queued expectation is consumed per clock edge or reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clockin or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pc !== e.pc || pc_valid !== e.valid || ras_count !== e.cnt || ras_underflow !== e.uf) begin
                    errors++;
                    $display("FAIL %s: got pc=%h v=%0b cnt=%0d uf=%0b, expected pc=%h v=%0b cnt=%0d uf=%0b",
                             e.name, pc, pc_valid, ras_count, ras_underflow, e.pc, e.valid, e.cnt, e.uf);
                end
            end
        end
    end

    task automatic expect_state(input string name, input logic [31:0] p, input logic v,
                                input logic [3:0] c, input logic u);
        exp_t e;
        e.name = name; e.pc = p; e.valid = v; e.cnt = c; e.uf = u;
        exp_q.push_back(e);
    endtask

    task automatic clear_in();
        stall = 0; trap = 0; redirect_valid = 0; redirect_call = 0;
        redirect_target = 32'h0; ret_valid = 0;
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge
    task automatic step(input string name, input logic [31:0] p, input logic [3:0] c, input logic u);
        expect_state(name, p, 1'b1, c, u);
        @(posedge clockin);
        @(negedge clockin);
        clear_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        @(negedge clockin);
        expect_state("reset_hold", 32'h0, 1'b0, 4'd0, 1'b0);
        @(negedge clockin);
        @(negedge clockin);

        // T1: requests on the first edge after release are ignored
        reset = 0;
        redirect_valid = 1; redirect_target = 32'h500; ret_valid = 1; trap = 0;
        step("t1_edge1", 32'h0, 4'd0, 1'b0);
        step("t1_edge2", 32'h4, 4'd0, 1'b0);
        step("t1_edge3", 32'h8, 4'd0, 1'b0);
        step("t1_edge4", 32'hC, 4'd0, 1'b0);
        expect_state("t1_mid_reset", 32'h0, 1'b0, 4'd0, 1'b0);
        #2 reset = 1;
        @(negedge clockin);
        @(negedge clockin);
        reset = 0;
        step("t1r_edge1", 32'h0, 4'd0, 1'b0);
        step("t1r_edge2", 32'h4, 4'd0, 1'b0);
        step("t1r_edge3", 32'h8, 4'd0, 1'b0);

        // T2: wrap at the top of the address space
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        step("t2_load_top", 32'hFFFF_FFFC, 4'd0, 1'b0);
        step("t2_wrap", 32'h0, 4'd0, 1'b0);

        // T3: call with misaligned target, then return
        redirect_valid = 1; redirect_target = 32'h100;
        step("t3_jump", 32'h100, 4'd0, 1'b0);
        redirect_valid = 1; redirect_call = 1; redirect_target = 32'h2003;
        step("t3_call", 32'h2000, 4'd1, 1'b0);
        ret_valid = 1;
        step("t3_ret", 32'h104, 4'd0, 1'b0);

        // T4: nine calls into an eight-deep stack, then drain past empty
        redirect_valid = 1; redirect_target = 32'h10;
        step("t4_jump", 32'h10, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            redirect_valid = 1; redirect_call = 1;
            redirect_target = (i == 8) ? 32'h1000 : 32'((i + 2) * 16);
            step($sformatf("t4_call%0d", i), redirect_target, (i < 8) ? 4'(i + 1) : 4'd8, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            ret_valid = 1;
            step($sformatf("t4_ret%0d", k), 32'h94 - 32'(k * 16), 4'(7 - k), 1'b0);
        end
        ret_valid = 1;
        step("t4_underflow", 32'h80, 4'd0, 1'b1);
        step("t4_uf_clear", 32'h84, 4'd0, 1'b0);

        // T5: stall suppresses ret and push but not redirect
        redirect_valid = 1; redirect_call = 1; redirect_target = 32'h300;
        step("t5_call", 32'h300, 4'd1, 1'b0);
        stall = 1; ret_valid = 1;
        step("t5_stall_ret", 32'h300, 4'd1, 1'b0);
        stall = 1; redirect_valid = 1; redirect_call = 1; redirect_target = 32'h400;
        step("t5_stall_redir", 32'h400, 4'd1, 1'b0);
        stall = 1;
        step("t5_stall_hold", 32'h400, 4'd1, 1'b0);
        ret_valid = 1;
        step("t5_ret", 32'h88, 4'd0, 1'b0);

        // T6: trap beats redirect and ret, then async reset between edges
        redirect_valid = 1; redirect_call = 1; redirect_target = 32'h500;
        step("t6_call1", 32'h500, 4'd1, 1'b0);
        redirect_valid = 1; redirect_call = 1; redirect_target = 32'h600;
        step("t6_call2", 32'h600, 4'd2, 1'b0);
        redirect_valid = 1; redirect_call = 1; redirect_target = 32'h700;
        step("t6_call3", 32'h700, 4'd3, 1'b0);
        trap = 1; redirect_valid = 1; redirect_call = 1; redirect_target = 32'h900; ret_valid = 1;
        step("t6_trap", 32'h80, 4'd0, 1'b0);
        step("t6_after_trap", 32'h84, 4'd0, 1'b0);
        expect_state("t6_async_reset", 32'h0, 1'b0, 4'd0, 1'b0);
        #2 reset = 1;
        @(negedge clockin);
        @(negedge clockin);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
